// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch, register read,
// execute, load/store access and write-back; halts on ebreak or illegal opcode.
module cpu_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             resume,
    output logic             mem_rstrb,
    output logic             mem_wstrb,
    output logic             addr_sel,
    output logic             instr_we,
    output logic             regs_re,
    output logic             rd_we,
    output logic             pc_we,
    output logic             halted,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH_INSTR = 4'd0,
        S_WAIT_INSTR  = 4'd1,
        S_FETCH_REGS  = 4'd2,
        S_EXECUTE     = 4'd3,
        S_LOAD        = 4'd4,
        S_WAIT_LOAD   = 4'd5,
        S_STORE       = 4'd6,
        S_WAIT_STORE  = 4'd7,
        S_HALT        = 4'd8
    } state_t;

    state_t           r_state, w_next;
    logic             r_illegal, w_illegal_nxt;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire;
    logic             w_rstrb, w_wstrb, w_asel, w_iwe, w_rre, w_rdwe, w_pcwe;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_FETCH_INSTR;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state   <= w_next;
            r_illegal <= w_illegal_nxt;
            if (w_retire) r_retired <= r_retired + CNT_W'(1);
        end
    end

    always_comb begin
        w_next        = r_state;
        w_illegal_nxt = r_illegal;
        w_retire      = 1'b0;
        w_rstrb       = 1'b0;
        w_wstrb       = 1'b0;
        w_asel        = 1'b0;
        w_iwe         = 1'b0;
        w_rre         = 1'b0;
        w_rdwe        = 1'b0;
        w_pcwe        = 1'b0;
        case (r_state)
            S_FETCH_INSTR: begin
                w_rstrb = 1'b1;
                w_next  = S_WAIT_INSTR;
            end
            S_WAIT_INSTR: if (mem_ready) begin
                w_iwe  = 1'b1;
                w_next = S_FETCH_REGS;
            end
            S_FETCH_REGS: begin
                w_rre  = 1'b1;
                w_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                case (opcode)
                    7'b0110011, 7'b0010011, 7'b1101111,
                    7'b1100111, 7'b0110111, 7'b0010111: begin
                        w_rdwe   = 1'b1;
                        w_pcwe   = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH_INSTR;
                    end
                    7'b1100011: begin
                        w_pcwe   = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH_INSTR;
                    end
                    7'b0000011: w_next = S_LOAD;
                    7'b0100011: w_next = S_STORE;
                    7'b1110011: w_next = S_HALT;
                    default: begin
                        w_illegal_nxt = 1'b1;
                        w_next        = S_HALT;
                    end
                endcase
            end
            S_LOAD: begin
                w_rstrb = 1'b1;
                w_asel  = 1'b1;
                w_next  = S_WAIT_LOAD;
            end
            S_WAIT_LOAD: begin
                w_asel = 1'b1;
                if (mem_ready) begin
                    w_rdwe   = 1'b1;
                    w_pcwe   = 1'b1;
                    w_retire = 1'b1;
                    w_next   = S_FETCH_INSTR;
                end
            end
            S_STORE: begin
                w_wstrb = 1'b1;
                w_asel  = 1'b1;
                w_next  = S_WAIT_STORE;
            end
            S_WAIT_STORE: begin
                w_asel = 1'b1;
                if (mem_ready) begin
                    w_pcwe   = 1'b1;
                    w_retire = 1'b1;
                    w_next   = S_FETCH_INSTR;
                end
            end
            S_HALT: if (resume) begin
                // ebreak counts as retired on resume; an illegal opcode does not
                w_pcwe        = 1'b1;
                w_retire      = ~r_illegal;
                w_illegal_nxt = 1'b0;
                w_next        = S_FETCH_INSTR;
            end
            default: w_next = S_FETCH_INSTR;
        endcase
    end

    // Reset parks the FSM in FETCH_INSTR, so strobes need explicit gating while held
    assign mem_rstrb = resetn & w_rstrb;
    assign mem_wstrb = resetn & w_wstrb;
    assign addr_sel  = resetn & w_asel;
    assign instr_we  = resetn & w_iwe;
    assign regs_re   = resetn & w_rre;
    assign rd_we     = resetn & w_rdwe;
    assign pc_we     = resetn & w_pcwe;
    assign halted    = (r_state == S_HALT);
    assign illegal   = r_illegal;
    assign state     = r_state;
    assign retired   = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: instruction-level model expands each
// instruction into its expected per-cycle output trace, checked every cycle.
module tb_cpu_sequencer;

    localparam int CNT_W = 32;
    localparam logic [7:0] F_RS = 8'h80, F_WS = 8'h40, F_AS = 8'h20, F_IW = 8'h10,
                           F_RR = 8'h08, F_RD = 8'h04, F_PC = 8'h02, F_HL = 8'h01;

    typedef struct packed {
        logic [3:0]       st;
        logic [7:0]       fl;
        logic             ill;
        logic [CNT_W-1:0] ret;
    } exp_t;

    logic             clk = 1'b0;
    logic             resetn;
    logic [6:0]       opcode;
    logic             mem_ready, resume;
    logic             mem_rstrb, mem_wstrb, addr_sel, instr_we, regs_re, rd_we, pc_we;
    logic             halted, illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    cpu_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .opcode(opcode), .mem_ready(mem_ready),
        .resume(resume), .mem_rstrb(mem_rstrb), .mem_wstrb(mem_wstrb),
        .addr_sel(addr_sel), .instr_we(instr_we), .regs_re(regs_re),
        .rd_we(rd_we), .pc_we(pc_we), .halted(halted), .illegal(illegal),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    int               vectors = 0, miscompares = 0;
    exp_t             q[$];
    logic [CNT_W-1:0] m_retired;
    logic             m_illegal;
    bit               done = 1'b0;

    task automatic chk(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs, queue expected outputs, then advance the model
    task automatic step(input logic [3:0] st, input logic [7:0] fl, input logic rdy,
                        input logic res, input logic [6:0] op, input int inc, input logic ill_nxt);
        exp_t e;
        mem_ready = rdy;
        resume    = res;
        opcode    = op;
        e.st = st; e.fl = fl; e.ill = m_illegal; e.ret = m_retired;
        q.push_back(e);
        @(posedge clk); #1;
        m_retired = m_retired + CNT_W'(inc);
        m_illegal = ill_nxt;
    endtask

    // di/dm: not-ready cycles before ready in the fetch/data wait; dh: idle HALT cycles
    task automatic run_instr(input logic [6:0] op, input int di, input int dm, input int dh);
        logic ill;
        step(4'd0, F_RS, 1'b1, 1'b0, 7'h73, 0, m_illegal);
        for (int i = 0; i < di; i++) step(4'd1, 8'h00, 1'b0, 1'b1, 7'h73, 0, m_illegal);
        step(4'd1, F_IW, 1'b1, 1'b0, 7'h73, 0, m_illegal);
        step(4'd2, F_RR, 1'b1, 1'b0, op, 0, m_illegal);
        case (op)
            7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111:
                step(4'd3, F_RD | F_PC, 1'b1, 1'b0, op, 1, m_illegal);
            7'b1100011:
                step(4'd3, F_PC, 1'b1, 1'b0, op, 1, m_illegal);
            7'b0000011: begin
                step(4'd3, 8'h00, 1'b1, 1'b0, op, 0, m_illegal);
                step(4'd4, F_RS | F_AS, 1'b1, 1'b0, op, 0, m_illegal);
                for (int i = 0; i < dm; i++) step(4'd5, F_AS, 1'b0, 1'b1, op, 0, m_illegal);
                step(4'd5, F_AS | F_RD | F_PC, 1'b1, 1'b0, op, 1, m_illegal);
            end
            7'b0100011: begin
                step(4'd3, 8'h00, 1'b1, 1'b0, op, 0, m_illegal);
                step(4'd6, F_WS | F_AS, 1'b1, 1'b0, op, 0, m_illegal);
                for (int i = 0; i < dm; i++) step(4'd7, F_AS, 1'b0, 1'b0, op, 0, m_illegal);
                step(4'd7, F_AS | F_PC, 1'b1, 1'b0, op, 1, m_illegal);
            end
            default: begin
                ill = (op != 7'b1110011);
                step(4'd3, 8'h00, 1'b0, 1'b0, op, 0, ill);
                for (int i = 0; i < dh; i++) step(4'd8, F_HL, i[0], 1'b0, 7'h13, 0, m_illegal);
                step(4'd8, F_HL | F_PC, 1'b0, 1'b1, 7'h13, m_illegal ? 0 : 1, 1'b0);
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; opcode = 7'h00; mem_ready = 1'b0; resume = 1'b0;
        m_retired = '0; m_illegal = 1'b0;
        fork
            begin
                exp_t e;
                while (!done) begin
                    @(negedge clk);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        vectors++;
                        if ({state, mem_rstrb, mem_wstrb, addr_sel, instr_we, regs_re, rd_we,
                             pc_we, halted, illegal, retired} !== e) begin
                            miscompares++;
                            $display("FAIL cycle vec %0d: got st=%0d fl=%b ill=%b ret=%0d expected st=%0d fl=%b ill=%b ret=%0d",
                                     vectors, state, {mem_rstrb, mem_wstrb, addr_sel, instr_we,
                                     regs_re, rd_we, pc_we, halted}, illegal, retired,
                                     e.st, e.fl, e.ill, e.ret);
                        end
                    end
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                chk("reset_state", CNT_W'(state), 0);
                chk("reset_retired", retired, 0);
                chk("reset_illegal", CNT_W'(illegal), 0);
                chk("reset_rstrb_forced", CNT_W'(mem_rstrb), 0);
                resetn = 1'b1;
                // 1: two ALU instructions, 4 cycles each
                run_instr(7'b0110011, 0, 0, 0);
                chk("alu1_retired", retired, 1);
                run_instr(7'b0010011, 0, 0, 0);
                chk("alu2_retired", retired, 2);
                // 2: load with ready three cycles after the strobe
                run_instr(7'b0000011, 0, 2, 0);
                chk("load_retired", retired, 3);
                // 3: store then branch, plus slow fetch and other jump opcodes
                run_instr(7'b0100011, 1, 1, 0);
                run_instr(7'b1100011, 0, 0, 0);
                chk("st_br_retired", retired, 5);
                run_instr(7'b1101111, 2, 0, 0);
                run_instr(7'b0110111, 0, 0, 0);
                chk("jal_lui_retired", retired, 7);
                // 4: ebreak, idle 10 cycles, resume retires
                run_instr(7'b1110011, 0, 0, 10);
                chk("ebreak_retired", retired, 8);
                // 5: illegal opcodes do not retire
                run_instr(7'b0000000, 0, 0, 3);
                run_instr(7'b0110010, 0, 0, 1);
                chk("illegal_retired", retired, 8);
                chk("illegal_cleared", CNT_W'(illegal), 0);
                // 6: reset in WAIT_LOAD with ready pending
                step(4'd0, F_RS, 1'b0, 1'b0, 7'h03, 0, m_illegal);
                step(4'd1, F_IW, 1'b1, 1'b0, 7'h03, 0, m_illegal);
                step(4'd2, F_RR, 1'b0, 1'b0, 7'h03, 0, m_illegal);
                step(4'd3, 8'h00, 1'b0, 1'b0, 7'h03, 0, m_illegal);
                step(4'd4, F_RS | F_AS, 1'b0, 1'b0, 7'h03, 0, m_illegal);
                chk("pre_reset_state", CNT_W'(state), 5);
                mem_ready = 1'b1;
                resetn = 1'b0;
                #1;
                chk("async_state", CNT_W'(state), 0);
                chk("async_retired", retired, 0);
                chk("async_enables", CNT_W'({mem_rstrb, mem_wstrb, addr_sel, instr_we,
                                             regs_re, rd_we, pc_we}), 0);
                m_retired = '0;
                m_illegal = 1'b0;
                @(posedge clk); #1;
                resetn = 1'b1;
                run_instr(7'b0010111, 0, 0, 0);
                chk("post_reset_retired", retired, 1);
                repeat (2) @(posedge clk);
                done = 1'b1;
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control FSM for the RV32I instruction decoder/datapath in the SOC. It owns no data. It sequences instruction fetch, register read, execute, load/store memory access and write-back by issuing one-cycle enables to the PC, instruction register, register file and memory port. It halts on SYSTEM (ebreak) or on an illegal opcode, and keeps a count of retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock (divided clock from Clockworks)
resetn  input  1  asynchronous active-low reset
opcode  input  7  instr[6:0] from the datapath instruction register; valid from FETCH_REGS onward
mem_ready  input  1  memory has completed the outstanding read/write (data valid on the read bus)
resume  input  1  one-cycle pulse; leaves HALT
mem_rstrb  output  1  one-cycle memory read request
mem_wstrb  output  1  one-cycle memory write request
addr_sel  output  1  memory address mux select: 0 = PC, 1 = rs1+imm (load/store)
instr_we  output  1  latch the memory read data into the instruction register
regs_re  output  1  read rs1/rs2 into the operand registers
rd_we  output  1  write back to rd (the datapath suppresses writes to x0)
pc_we  output  1  commit the next PC
halted  output  1  high while in HALT
illegal  output  1  sticky; set when HALT was entered on an undecodable opcode
state  output  4  current state code (debug/LEDs)
retired  output  CNT_W  count of retired instructions

Behaviour:
- Reset: async on resetn low.
  - Register values: state=FETCH_INSTR, retired=0, illegal=0.
  - All strobes/enables are forced 0 while resetn is low.
  - The first mem_rstrb occurs in the first cycle after release.
- State codes: FETCH_INSTR=0, WAIT_INSTR=1, FETCH_REGS=2, EXECUTE=3, LOAD=4, WAIT_LOAD=5, STORE=6, WAIT_STORE=7, HALT=8.
- FETCH_INSTR: mem_rstrb=1, addr_sel=0 -> WAIT_INSTR.
- WAIT_INSTR: hold until mem_ready=1; in that cycle instr_we=1 -> FETCH_REGS.
- FETCH_REGS: regs_re=1 -> EXECUTE.
- EXECUTE: decode opcode; bits [1:0] must be 2'b11.
  - ALUreg 0110011, ALUimm 0010011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111: rd_we=1, pc_we=1, retired+1 -> FETCH_INSTR.
  - Branch 1100011: pc_we=1, rd_we=0, retired+1 -> FETCH_INSTR.
  - Load 0000011 -> LOAD.
  - Store 0100011 -> STORE.
  - SYSTEM 1110011 -> HALT, no pc_we, no retire.
  - Any other value -> HALT, with illegal<=1.
- LOAD: mem_rstrb=1, addr_sel=1 -> WAIT_LOAD.
- WAIT_LOAD: addr_sel=1. Hold until mem_ready; in that cycle rd_we=1, pc_we=1, retired+1 -> FETCH_INSTR.
- STORE: mem_wstrb=1, addr_sel=1 -> WAIT_STORE.
- WAIT_STORE: addr_sel=1. Hold until mem_ready; in that cycle pc_we=1, retired+1 -> FETCH_INSTR.
- HALT: halted=1; no strobes are issued.
  - resume=1: pc_we=1 (steps over the halting instruction), illegal<=0, -> FETCH_INSTR.
  - retired+1 only if the halt was caused by SYSTEM (illegal was 0).
- Output timing:
  - Moore outputs decode state only.
  - instr_we, and rd_we/pc_we in the WAIT states and in HALT, are Mealy: qualified by mem_ready or resume in the same cycle.
- mem_ready rules:
  - mem_ready is sampled only in WAIT_INSTR, WAIT_LOAD and WAIT_STORE.
  - It is ignored in the strobe cycle and in all other states, so a memory must assert ready no earlier than the cycle after the strobe.
  - Exactly one strobe is issued per access, never re-issued while waiting.
- resume outside HALT is ignored.
- Latency with ready one cycle after the strobe:
  - ALU/branch/jump instructions take 4 cycles.
  - Load/store instructions take 6 cycles.
  - Each extra wait cycle adds one cycle.
- retired wraps modulo 2^CNT_W without a flag.
- At most one of mem_rstrb/mem_wstrb is high in any cycle; pc_we is high at most once per instruction.
- Reset mid-access (any state) aborts immediately; the pending mem_ready is not consumed.

Test Plan:
1. Release reset, memory ready 1 cycle after strobe, opcode=0110011 -> state 0,1,2,3,0; instr_we in cycle 2; rd_we and pc_we in cycle 4; retired=1 after 4 cycles; second instruction retired=2 at cycle 8.
2. opcode=0000011, ready delayed 3 cycles after the LOAD strobe -> WAIT_LOAD held for 3 cycles with addr_sel=1; rd_we and pc_we only in the ready cycle; 8 cycles total; retired increments by 1.
3. opcode=0100011, then 1100011 -> store: mem_wstrb for exactly 1 cycle, addr_sel=1, rd_we never high; branch: pc_we=1, rd_we=0 in EXECUTE; retired +2.
4. opcode=1110011 -> HALT, halted=1, state=8, no pc_we; hold for 10 cycles with mem_ready toggling -> no strobes, retired constant; resume pulse -> pc_we=1, retired+1, state=0 next cycle.
5. opcode=0000000 -> HALT with illegal=1, retired unchanged; resume -> illegal=0, pc_we=1, retired still unchanged.
6. Assert resetn low in WAIT_LOAD while mem_ready=1 -> state=0, retired=0, all strobes 0 immediately (asynchronously); release -> mem_rstrb=1 in the first cycle after release.
